// File: rtl/operands_pkg.sv
`default_nettype none
// ============================================================================
// Package     : operands_pkg
// Description : Shared defaults, derived dimension widths and the reader
//               state encoding for the operand register file read path.
// Revision    : 1.0 - initial release
// ============================================================================
package operands_pkg;

  // Default geometry of the operand store
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BUS_WIDTH  = 64;
  localparam int DEF_ADDR_WIDTH = 32;

  // Elements per row; also the largest legal row count
  localparam int DEF_MAX_DIM = DEF_BUS_WIDTH / DEF_DATA_WIDTH;
  // One spare bit so MAX_DIM itself (and illegal values above it) fit
  localparam int DEF_DIM_W   = $clog2(DEF_MAX_DIM) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/operand_row_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : operand_row_unpacker
// Description : Holds one operand row captured from the store and selects a
//               single DATA_WIDTH element from it by column index. Element 0
//               occupies the least significant bits of the row.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_row_unpacker
  import operands_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int BUS_WIDTH  = DEF_BUS_WIDTH,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int DIM_W      = $clog2(MAX_DIM) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [BUS_WIDTH-1:0]  row_i,
  input  logic [DIM_W-1:0]      col_sel_i,
  output logic [DATA_WIDTH-1:0] elem_o
);

  logic [BUS_WIDTH-1:0] row_d;
  logic [BUS_WIDTH-1:0] row_q;

  // Replace the buffered row only when a fetch completes
  always_comb begin
    row_d = row_q;
    if (load_i) begin
      row_d = row_i;
    end
  end

  // Row buffer register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  // Column mux; an out-of-range select yields zero rather than garbage
  always_comb begin
    elem_o = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (col_sel_i == DIM_W'(i)) begin
        elem_o = row_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand_reader.sv
`default_nettype none
// ============================================================================
// Module      : operand_reader
// Description : Streams a rows x cols matrix from the operand store to the
//               compute datapath, one element per valid/ready handshake,
//               row-major, tagged with row/column indices. One fetch cycle
//               per row reads the store's asynchronous port into a buffer.
// Build macro : OPERAND_READER_ZERO_PAD_EN - every row streams MAX_DIM
//               elements; columns at or beyond num_cols are driven as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_reader
  import operands_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int DIM_W      = $clog2(MAX_DIM) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [DIM_W-1:0]      num_rows_i,
  input  logic [DIM_W-1:0]      num_cols_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [BUS_WIDTH-1:0]  mem_data_i,
  input  logic                  mem_busy_i,
  output logic [DATA_WIDTH-1:0] elem_o,
  output logic                  elem_valid_o,
  input  logic                  elem_ready_i,
  output logic [DIM_W-1:0]      row_idx_o,
  output logic [DIM_W-1:0]      col_idx_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [DIM_W-1:0] MAX_DIM_V = DIM_W'(MAX_DIM);

  rd_state_e             state_d, state_q;
  logic [ADDR_WIDTH-1:0] base_d,  base_q;
  logic [DIM_W-1:0]      rows_d,  rows_q;
  logic [DIM_W-1:0]      cols_d,  cols_q;
  logic [DIM_W-1:0]      row_d,   row_q;
  logic [DIM_W-1:0]      col_d,   col_q;
  logic                  err_d,   err_q;

  logic                  load_row;
  logic                  dims_bad;
  logic [DIM_W-1:0]      last_col;
  logic [DIM_W-1:0]      last_row;
  logic                  at_last_col;
  logic                  at_last_row;
  logic [DATA_WIDTH-1:0] raw_elem;

  assign dims_bad = (num_rows_i == '0) || (num_rows_i > MAX_DIM_V) ||
                    (num_cols_i == '0) || (num_cols_i > MAX_DIM_V);

  assign last_row    = rows_q - DIM_W'(1);
  assign at_last_row = (row_q == last_row);
  assign at_last_col = (col_q == last_col);

`ifdef OPERAND_READER_ZERO_PAD_EN
  assign last_col = DIM_W'(MAX_DIM - 1);
  assign elem_o   = (col_q >= cols_q) ? '0 : raw_elem;
`else
  assign last_col = cols_q - DIM_W'(1);
  assign elem_o   = raw_elem;
`endif

  // Store address wraps naturally at ADDR_WIDTH bits
  assign mem_addr_o   = base_q + ADDR_WIDTH'(row_q);
  assign elem_valid_o = (state_q == ST_STREAM);
  assign row_idx_o    = row_q;
  assign col_idx_o    = col_q;
  assign last_o       = elem_valid_o && at_last_row && at_last_col;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = done_o && err_q;

  // Next-state, counter and command-capture logic
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    row_d    = row_q;
    col_d    = col_q;
    err_d    = err_q;
    load_row = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d = base_addr_i;
          rows_d = num_rows_i;
          cols_d = num_cols_i;
          if (dims_bad) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            row_d   = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        // Read data is only trustworthy while no store write is in flight
        if (!mem_busy_i) begin
          load_row = 1'b1;
          col_d    = '0;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (elem_ready_i) begin
          if (at_last_col) begin
            if (at_last_row) begin
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + DIM_W'(1);
              state_d = ST_FETCH;
            end
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and counters; reset abandons any transfer in progress
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
    end
  end

  operand_row_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH)
  ) u_unpacker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load_row),
    .row_i     (mem_data_i),
    .col_sel_i (col_q),
    .elem_o    (raw_elem)
  );

endmodule
`default_nettype wire

// File: tb/tb_operand_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_reader
// Description : Directed self-checking bench for operand_reader. Build with
//               OPERAND_READER_ZERO_PAD_EN defined to exercise zero padding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_reader;

  localparam int DW = 32;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int DIMW = 2;

  logic            clk_i;
  logic            rst_i;
  logic            start_i;
  logic [AW-1:0]   base_addr_i;
  logic [DIMW-1:0] num_rows_i;
  logic [DIMW-1:0] num_cols_i;
  logic [AW-1:0]   mem_addr_o;
  logic [BW-1:0]   mem_data_i;
  logic            mem_busy_i;
  logic [DW-1:0]   elem_o;
  logic            elem_valid_o;
  logic            elem_ready_i;
  logic [DIMW-1:0] row_idx_o;
  logic [DIMW-1:0] col_idx_o;
  logic            last_o;
  logic            busy_o;
  logic            done_o;
  logic            err_o;

  int errors = 0;
  int checks = 0;

  // Operand store model: asynchronous read, garbage while a write is pending
  logic [BW-1:0] store [0:3];
  assign mem_data_i = mem_busy_i ? 64'hDEAD_BEEF_DEAD_BEEF : store[mem_addr_o[1:0]];

  // Handshakes and fetch addresses captured by the collector
  logic [DW-1:0]   hs_e [0:15];
  logic [DIMW-1:0] hs_r [0:15];
  logic [DIMW-1:0] hs_c [0:15];
  logic            hs_l [0:15];
  logic [AW-1:0]   fa   [0:7];

  operand_reader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .num_rows_i   (num_rows_i),
    .num_cols_i   (num_cols_i),
    .mem_addr_o   (mem_addr_o),
    .mem_data_i   (mem_data_i),
    .mem_busy_i   (mem_busy_i),
    .elem_o       (elem_o),
    .elem_valid_o (elem_valid_o),
    .elem_ready_i (elem_ready_i),
    .row_idx_o    (row_idx_o),
    .col_idx_o    (col_idx_o),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] base, input logic [DIMW-1:0] r, input logic [DIMW-1:0] c);
    base_addr_i = base;
    num_rows_i  = r;
    num_cols_i  = c;
    start_i     = 1'b1;
  endtask

  // Runs one transfer until done_o (bounded), recording every handshake
  task automatic collect(input bit bp, input bit poke, output int n_hs, output int n_done,
                         output int n_err, output int n_stall_bad, output int n_fetch);
    logic [DW-1:0]   pe;
    logic [DIMW-1:0] pr, pc;
    bit              stall;
    bit              pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    n_hs = 0; n_done = 0; n_err = 0; n_stall_bad = 0; n_fetch = 0;
    stall = 1'b0; pe = '0; pr = '0; pc = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      start_i = 1'b0;
      if (stall && (elem_valid_o !== 1'b1 || elem_o !== pe || row_idx_o !== pr || col_idx_o !== pc))
        n_stall_bad++;
      if (poke && i == 3) begin
        start_i    = 1'b1;
        num_rows_i = '0;
        num_cols_i = '0;
      end
      elem_ready_i = bp ? pat[i%4] : 1'b1;
      if (busy_o && !elem_valid_o && !done_o && n_fetch < 8) begin
        fa[n_fetch] = mem_addr_o;
        n_fetch++;
      end
      if (elem_valid_o && elem_ready_i && n_hs < 16) begin
        hs_e[n_hs] = elem_o; hs_r[n_hs] = row_idx_o; hs_c[n_hs] = col_idx_o; hs_l[n_hs] = last_o;
        n_hs++;
      end
      stall = elem_valid_o && !elem_ready_i;
      pe = elem_o; pr = row_idx_o; pc = col_idx_o;
      if (done_o) begin
        n_done++;
        if (err_o) n_err++;
        break;
      end
    end
    start_i      = 1'b0;
    elem_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({elem_valid_o, busy_o, done_o, err_o, last_o, elem_o, row_idx_o, col_idx_o, mem_addr_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v%b b%b d%b e%b l%b elem=%h addr=%h want all zero",
               elem_valid_o, busy_o, done_o, err_o, last_o, elem_o, mem_addr_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_normal();
    bit            ev [8] = '{0, 1, 1, 0, 1, 1, 0, 0};
    bit            eb [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    bit            ed [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    bit            el [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic [DW-1:0] ee [8] = '{0, 1, 2, 0, 3, 4, 0, 0};
    logic [1:0]    er [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    logic [1:0]    ec [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    issue(32'd0, 2'd2, 2'd2);
    elem_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      start_i = 1'b0;
      checks++;
      if ({elem_valid_o, busy_o, done_o, err_o, last_o} !== {ev[k], eb[k], ed[k], 1'b0, el[k]}) begin
        errors++;
        $display("FAIL normal_ctl cyc%0d got v/b/d/e/l=%b want %b", k + 1,
                 {elem_valid_o, busy_o, done_o, err_o, last_o}, {ev[k], eb[k], ed[k], 1'b0, el[k]});
      end
      if (ev[k]) begin
        checks++;
        if ({elem_o, row_idx_o, col_idx_o} !== {ee[k], er[k], ec[k]}) begin
          errors++;
          $display("FAIL normal_elem cyc%0d got elem=%0d r=%0d c=%0d want elem=%0d r=%0d c=%0d",
                   k + 1, elem_o, row_idx_o, col_idx_o, ee[k], er[k], ec[k]);
        end
      end
      if (k == 0 || k == 3) begin
        checks++;
        if (mem_addr_o !== ((k == 0) ? 32'd0 : 32'd1)) begin
          errors++;
          $display("FAIL normal_fetch_addr cyc%0d got %h want %h", k + 1, mem_addr_o, (k == 0) ? 32'd0 : 32'd1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] xe [4] = '{1, 2, 3, 4};
    logic [1:0]    xr [4] = '{0, 0, 1, 1};
    logic [1:0]    xc [4] = '{0, 1, 0, 1};
    bit            xl [4] = '{0, 0, 0, 1};
    int n_hs, n_done, n_err, n_bad, n_fetch;
    issue(32'd0, 2'd2, 2'd2);
    collect(1'b1, 1'b1, n_hs, n_done, n_err, n_bad, n_fetch);
    checks++;
    if (n_done != 1 || n_err != 0) begin
      errors++;
      $display("FAIL bp_done got done=%0d err=%0d want done=1 err=0", n_done, n_err);
    end
    checks++;
    if (n_hs != 4 || n_bad != 0) begin
      errors++;
      $display("FAIL bp_handshakes got hs=%0d unstable=%0d want hs=4 unstable=0", n_hs, n_bad);
    end
    for (int j = 0; j < 4 && j < n_hs; j++) begin
      checks++;
      if ({hs_e[j], hs_r[j], hs_c[j], hs_l[j]} !== {xe[j], xr[j], xc[j], xl[j]}) begin
        errors++;
        $display("FAIL bp_elem%0d got %0d (%0d,%0d) last=%b want %0d (%0d,%0d) last=%b",
                 j, hs_e[j], hs_r[j], hs_c[j], hs_l[j], xe[j], xr[j], xc[j], xl[j]);
      end
    end
    tick();
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      errors++;
      $display("FAIL bp_idle_after_done got busy/done=%b want 00", {busy_o, done_o});
    end
  endtask

  task automatic test_store_busy();
    issue(32'd0, 2'd2, 2'd2);
    elem_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    store[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    checks++;
    if (elem_valid_o !== 1'b1 || elem_o !== 32'd2) begin
      errors++;
      $display("FAIL capture_at_fetch got v=%b elem=%h want v=1 elem=2", elem_valid_o, elem_o);
    end
    store[0] = 64'h2_0000_0001;
    tick();
    mem_busy_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      if (k == 3) mem_busy_i = 1'b0;
      checks++;
      if (elem_valid_o !== 1'b0 || busy_o !== 1'b1 || mem_addr_o !== 32'd1) begin
        errors++;
        $display("FAIL busy_hold k%0d got v=%b busy=%b addr=%h want v=0 busy=1 addr=1",
                 k, elem_valid_o, busy_o, mem_addr_o);
      end
    end
    tick();
    checks++;
    if ({elem_valid_o, elem_o, row_idx_o, col_idx_o} !== {1'b1, 32'd3, 2'd1, 2'd0}) begin
      errors++;
      $display("FAIL busy_resume got v=%b elem=%h r=%0d c=%0d want v=1 elem=3 r=1 c=0",
               elem_valid_o, elem_o, row_idx_o, col_idx_o);
    end
    tick();
    tick();
    checks++;
    if ({done_o, err_o} !== 2'b10) begin
      errors++;
      $display("FAIL busy_done got done/err=%b want 10", {done_o, err_o});
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [1:0] rr [3] = '{2'd0, 2'd2, 2'd3};
    logic [1:0] cc [3] = '{2'd2, 2'd3, 2'd1};
    for (int t = 0; t < 3; t++) begin
      issue(32'd0, rr[t], cc[t]);
      tick();
      start_i = 1'b0;
      checks++;
      if ({elem_valid_o, busy_o, done_o, err_o} !== 4'b0111) begin
        errors++;
        $display("FAIL illegal%0d_pulse got v/b/d/e=%b want 0111", t, {elem_valid_o, busy_o, done_o, err_o});
      end
      tick();
      checks++;
      if ({elem_valid_o, busy_o, done_o, err_o} !== 4'b0000) begin
        errors++;
        $display("FAIL illegal%0d_after got v/b/d/e=%b want 0000", t, {elem_valid_o, busy_o, done_o, err_o});
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_hs, n_done, n_err, n_bad, n_fetch;
    int seen_done;
    issue(32'd0, 2'd2, 2'd2);
    elem_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    checks++;
    if ({elem_valid_o, busy_o, done_o, err_o, last_o, elem_o, row_idx_o, col_idx_o, mem_addr_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got v%b b%b d%b addr=%h elem=%h want all zero",
               elem_valid_o, busy_o, done_o, mem_addr_o, elem_o);
    end
    tick();
    rst_i = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done_o || busy_o) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL reset_mid_abandon got %0d active cycles want 0", seen_done);
    end
    issue(32'd0, 2'd2, 2'd2);
    collect(1'b0, 1'b0, n_hs, n_done, n_err, n_bad, n_fetch);
    checks++;
    if (n_done != 1 || n_hs != 4 || hs_e[0] !== 32'd1 || hs_r[0] !== 2'd0 || hs_c[0] !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_restart got done=%0d hs=%0d first=%0d (%0d,%0d) want done=1 hs=4 first=1 (0,0)",
               n_done, n_hs, hs_e[0], hs_r[0], hs_c[0]);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [DW-1:0] xe [4] = '{5, 6, 1, 2};
    int n_hs, n_done, n_err, n_bad, n_fetch;
    tick();
    issue(32'hFFFF_FFFF, 2'd2, 2'd2);
    collect(1'b0, 1'b0, n_hs, n_done, n_err, n_bad, n_fetch);
    checks++;
    if (n_fetch != 2 || fa[0] !== 32'hFFFF_FFFF || fa[1] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_addr got n=%0d a0=%h a1=%h want n=2 a0=ffffffff a1=00000000",
               n_fetch, fa[0], fa[1]);
    end
    checks++;
    if (n_hs != 4 || n_done != 1) begin
      errors++;
      $display("FAIL wrap_count got hs=%0d done=%0d want hs=4 done=1", n_hs, n_done);
    end
    for (int j = 0; j < 4 && j < n_hs; j++) begin
      checks++;
      if (hs_e[j] !== xe[j]) begin
        errors++;
        $display("FAIL wrap_elem%0d got %0d want %0d", j, hs_e[j], xe[j]);
      end
    end
    tick();
  endtask

  task automatic test_narrow_cols();
    int n_hs, n_done, n_err, n_bad, n_fetch;
`ifdef OPERAND_READER_ZERO_PAD_EN
    localparam int NX = 4;
    logic [DW-1:0] xe [NX] = '{1, 0, 3, 0};
    logic [1:0]    xr [NX] = '{0, 0, 1, 1};
    logic [1:0]    xc [NX] = '{0, 1, 0, 1};
    bit            xl [NX] = '{0, 0, 0, 1};
`else
    localparam int NX = 2;
    logic [DW-1:0] xe [NX] = '{1, 3};
    logic [1:0]    xr [NX] = '{0, 1};
    logic [1:0]    xc [NX] = '{0, 0};
    bit            xl [NX] = '{0, 1};
`endif
    issue(32'd0, 2'd2, 2'd1);
    collect(1'b0, 1'b0, n_hs, n_done, n_err, n_bad, n_fetch);
    checks++;
    if (n_hs != NX || n_done != 1 || n_err != 0) begin
      errors++;
      $display("FAIL narrow_count got hs=%0d done=%0d err=%0d want hs=%0d done=1 err=0",
               n_hs, n_done, n_err, NX);
    end
    for (int j = 0; j < NX && j < n_hs; j++) begin
      checks++;
      if ({hs_e[j], hs_r[j], hs_c[j], hs_l[j]} !== {xe[j], xr[j], xc[j], xl[j]}) begin
        errors++;
        $display("FAIL narrow_elem%0d got %0d (%0d,%0d) last=%b want %0d (%0d,%0d) last=%b",
                 j, hs_e[j], hs_r[j], hs_c[j], hs_l[j], xe[j], xr[j], xc[j], xl[j]);
      end
    end
    tick();
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    base_addr_i  = '0;
    num_rows_i   = '0;
    num_cols_i   = '0;
    mem_busy_i   = 1'b0;
    elem_ready_i = 1'b0;
    store[0] = 64'h0000_0002_0000_0001;
    store[1] = 64'h0000_0004_0000_0003;
    store[2] = 64'h0000_0008_0000_0007;
    store[3] = 64'h0000_0006_0000_0005;
    test_reset();
    test_normal();
    test_backpressure();
    test_store_busy();
    test_illegal();
    test_reset_mid();
    test_back_to_back_wrap();
    test_narrow_cols();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
